// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive watchdog on the traffic light controller outputs.
// Classifies the lamp code into phases, times each segment and flags bad codes, sequences and durations.
module traffic_light_monitor #(
  parameter int CW             = 8,
  parameter int GREEN_CYC      = 61,
  parameter int PREF_GREEN_CYC = 81,
  parameter int YELLOW_CYC     = 7,
  parameter int RED_CYC        = 5,
  parameter int BLINK_CYC      = 3,
  parameter int TOL            = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    leds,
  input  logic          attention,
  input  logic          preferential,
  input  logic          force_red,
  input  logic          err_clr,
  output logic [2:0]    state,
  output logic          dur_valid,
  output logic [2:0]    dur_phase,
  output logic [CW-1:0] dur_cycles,
  output logic          cycle_done,
  output logic [15:0]   cycle_count,
  output logic          illegal_err,
  output logic          seq_err,
  output logic          time_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GREEN     = 3'd1,
    S_YELLOW    = 3'd2,
    S_RED       = 3'd3,
    S_BLINK_ON  = 3'd4,
    S_BLINK_OFF = 3'd5
  } state_t;

  state_t        cur;
  logic [2:0]    prev_leds;
  logic [CW-1:0] cnt;

  // A lamp change is captured here on the edge it is seen and judged one edge later.
  logic          ev_pend;
  logic [2:0]    ev_leds;
  logic [CW-1:0] ev_cnt;
  logic          ev_att;
  logic          ev_pref;
  logic          ev_force;

  logic          green_first;
  logic          blink_fresh;
  logic          red_from_yellow;

  state_t        nxt;
  logic          code_ok;
  logic          trans_ok;
  logic          dur_chk;
  logic          dur_bad;
  logic          loop_hit;
  logic          cur_blink;
  logic          nxt_blink;
  logic [CW-1:0] exp_cyc;
  logic [CW-1:0] diff;

  assign state = cur;

  always_comb begin
    code_ok = (ev_leds == 3'b100) || (ev_leds == 3'b010) ||
              (ev_leds == 3'b001) || (ev_leds == 3'b000);

    case (ev_leds)
      3'b100:  nxt = S_GREEN;
      3'b010:  nxt = (cur == S_GREEN) ? S_YELLOW : S_BLINK_ON;
      3'b001:  nxt = S_RED;
      3'b000:  nxt = ev_att ? S_BLINK_OFF : S_IDLE;
      default: nxt = S_IDLE;
    endcase

    cur_blink = (cur == S_BLINK_ON) || (cur == S_BLINK_OFF);
    nxt_blink = (nxt == S_BLINK_ON) || (nxt == S_BLINK_OFF);

    // Dropping to IDLE (including via a bad code) or going dark under attention is always allowed.
    if (!code_ok || nxt == S_IDLE || nxt == S_BLINK_OFF) begin
      trans_ok = 1'b1;
    end else begin
      case (cur)
        S_IDLE:      trans_ok = 1'b1;
        S_GREEN:     trans_ok = (nxt == S_YELLOW) || (nxt == S_RED && ev_force);
        S_YELLOW:    trans_ok = (nxt == S_RED);
        S_RED:       trans_ok = (nxt == S_GREEN);
        S_BLINK_ON:  trans_ok = (nxt == S_GREEN) && !ev_att;
        S_BLINK_OFF: trans_ok = (nxt == S_BLINK_ON) || (nxt == S_GREEN && !ev_att);
        default:     trans_ok = 1'b0;
      endcase
    end

    dur_chk = 1'b0;
    exp_cyc = '0;
    if (code_ok && nxt != S_IDLE) begin
      if (cur == S_GREEN && nxt == S_YELLOW && !green_first) begin
        dur_chk = 1'b1;
        exp_cyc = ev_pref ? CW'(PREF_GREEN_CYC) : CW'(GREEN_CYC);
      end else if (cur == S_YELLOW && nxt == S_RED) begin
        dur_chk = 1'b1;
        exp_cyc = CW'(YELLOW_CYC);
      end else if (cur == S_RED && nxt == S_GREEN) begin
        dur_chk = 1'b1;
        exp_cyc = CW'(RED_CYC);
      end else if (cur == S_BLINK_ON && nxt == S_BLINK_OFF) begin
        dur_chk = 1'b1;
        exp_cyc = CW'(BLINK_CYC);
      end else if (cur == S_BLINK_OFF && nxt == S_BLINK_ON && !blink_fresh) begin
        dur_chk = 1'b1;
        exp_cyc = CW'(BLINK_CYC);
      end
    end

    diff = (ev_cnt > exp_cyc) ? (ev_cnt - exp_cyc) : (exp_cyc - ev_cnt);

    // A saturated count carries no length; only a stuck yellow or red is a timing fault.
    if (&ev_cnt) begin
      dur_bad = code_ok && (nxt != S_IDLE) && (cur == S_YELLOW || cur == S_RED);
    end else begin
      dur_bad = dur_chk && (diff > CW'(TOL));
    end

    loop_hit = code_ok && (cur == S_RED) && (nxt == S_GREEN) && red_from_yellow;
  end

  // dur_valid is a single-cycle strobe with no back-pressure; dur_phase/dur_cycles are
  // meaningful only while it is high and hold their last report otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur             <= S_IDLE;
      prev_leds       <= 3'b000;
      cnt             <= '0;
      ev_pend         <= 1'b0;
      ev_leds         <= 3'b000;
      ev_cnt          <= '0;
      ev_att          <= 1'b0;
      ev_pref         <= 1'b0;
      ev_force        <= 1'b0;
      green_first     <= 1'b0;
      blink_fresh     <= 1'b0;
      red_from_yellow <= 1'b0;
      dur_valid       <= 1'b0;
      dur_phase       <= 3'd0;
      dur_cycles      <= '0;
      cycle_done      <= 1'b0;
      cycle_count     <= 16'd0;
      illegal_err     <= 1'b0;
      seq_err         <= 1'b0;
      time_err        <= 1'b0;
    end else begin
      prev_leds <= leds;
      if (leds != prev_leds) begin
        cnt <= CW'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + CW'(1);
      end

      ev_pend  <= (leds != prev_leds);
      ev_leds  <= leds;
      ev_cnt   <= cnt;
      ev_att   <= attention;
      ev_pref  <= preferential;
      ev_force <= force_red;

      dur_valid  <= 1'b0;
      cycle_done <= 1'b0;

      if (err_clr) begin
        illegal_err <= 1'b0;
        seq_err     <= 1'b0;
        time_err    <= 1'b0;
      end

      if (ev_pend) begin
        cur <= nxt;
        if (cur != S_IDLE) begin
          dur_valid  <= 1'b1;
          dur_phase  <= cur;
          dur_cycles <= ev_cnt;
        end

        if (!code_ok)  illegal_err <= 1'b1;
        if (!trans_ok) seq_err     <= 1'b1;
        if (dur_bad)   time_err    <= 1'b1;

        green_first     <= (nxt == S_GREEN) && (cur == S_IDLE);
        red_from_yellow <= (nxt == S_RED) && (cur == S_YELLOW);
        // Fresh until the first dark half-period of a blink run has ended.
        if (!nxt_blink) begin
          blink_fresh <= 1'b0;
        end else if (!cur_blink) begin
          blink_fresh <= 1'b1;
        end else if (cur == S_BLINK_OFF) begin
          blink_fresh <= 1'b0;
        end

        if (loop_hit) begin
          cycle_done <= 1'b1;
          if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed plus randomized lamp sequences checked against a
// segment-level reference model built from the phase history.
module tb_traffic_light_monitor;

  localparam int PH_IDLE = 0, PH_G = 1, PH_Y = 2, PH_R = 3, PH_BON = 4, PH_BOFF = 5;
  localparam int SAT = 255;
  localparam int TOL = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  leds = 3'b000;
  logic        attention = 1'b0;
  logic        preferential = 1'b0;
  logic        force_red = 1'b0;
  logic        err_clr = 1'b0;
  logic [2:0]  state;
  logic        dur_valid;
  logic [2:0]  dur_phase;
  logic [7:0]  dur_cycles;
  logic        cycle_done;
  logic [15:0] cycle_count;
  logic        illegal_err;
  logic        seq_err;
  logic        time_err;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .leds(leds), .attention(attention),
    .preferential(preferential), .force_red(force_red), .err_clr(err_clr),
    .state(state), .dur_valid(dur_valid), .dur_phase(dur_phase),
    .dur_cycles(dur_cycles), .cycle_done(cycle_done), .cycle_count(cycle_count),
    .illegal_err(illegal_err), .seq_err(seq_err), .time_err(time_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [2:0] m_prev;
  int         m_cnt;
  int         m_state;
  int         m_ccount;
  bit         m_ill, m_seq, m_time;
  int         hist[$];
  bit         p_due, p_dv, p_cd, p_ill, p_seq, p_time;
  int         p_state, p_phase, p_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int phase_of(input logic [2:0] l, input bit a, input int cur);
    case (l)
      3'b100:  return PH_G;
      3'b010:  return (cur == PH_G) ? PH_Y : PH_BON;
      3'b001:  return PH_R;
      3'b000:  return a ? PH_BOFF : PH_IDLE;
      default: return PH_IDLE;
    endcase
  endfunction

  function automatic bit allowed(input int from, input int to, input bit a, input bit f);
    if (to == PH_IDLE || to == PH_BOFF) return 1'b1;
    if (from == PH_IDLE) return 1'b1;
    if (from == PH_G && to == PH_Y) return 1'b1;
    if (from == PH_G && to == PH_R) return f;
    if (from == PH_Y && to == PH_R) return 1'b1;
    if (from == PH_R && to == PH_G) return 1'b1;
    if (from == PH_BOFF && to == PH_BON) return 1'b1;
    if ((from == PH_BON || from == PH_BOFF) && to == PH_G) return !a;
    return 1'b0;
  endfunction

  // Number of dark half-periods in the blink run that ends the history.
  function automatic int offs_in_run();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != PH_BON && hist[i] != PH_BOFF) break;
      if (hist[i] == PH_BOFF) n++;
    end
    return n;
  endfunction

  task automatic model_event(input logic [2:0] l, input bit a, input bit p, input bit f, input int c);
    int cur = m_state;
    int nxt;
    int e = -1;
    bit ill = !(l == 3'b100 || l == 3'b010 || l == 3'b001 || l == 3'b000);
    nxt = ill ? PH_IDLE : phase_of(l, a, cur);
    p_dv = (cur != PH_IDLE);
    p_phase = cur;
    p_cycles = c;
    p_ill = ill;
    p_seq = !ill && !allowed(cur, nxt, a, f);
    p_time = 1'b0;
    if (!ill && nxt != PH_IDLE) begin
      if (c == SAT) begin
        p_time = (cur == PH_Y || cur == PH_R);
      end else begin
        if (cur == PH_G && nxt == PH_Y && !(hist.size() >= 2 && hist[hist.size()-2] == PH_IDLE))
          e = p ? 81 : 61;
        if (cur == PH_Y && nxt == PH_R) e = 7;
        if (cur == PH_R && nxt == PH_G) e = 5;
        if (cur == PH_BON && nxt == PH_BOFF) e = 3;
        if (cur == PH_BOFF && nxt == PH_BON && offs_in_run() > 1) e = 3;
        if (e >= 0) p_time = ((c > e) ? c - e : e - c) > TOL;
      end
    end
    p_cd = !ill && cur == PH_R && nxt == PH_G && hist.size() >= 3 &&
           hist[hist.size()-3] == PH_G && hist[hist.size()-2] == PH_Y;
    hist.push_back(nxt);
    if (hist.size() > 32) void'(hist.pop_front());
    p_state = nxt;
    p_due = 1'b1;
  endtask

  task automatic compare(input bit due);
    bit dv = due && p_dv;
    chk("state", state, m_state);
    chk("dur_valid", dur_valid, dv);
    if (dv) begin
      chk("dur_phase", dur_phase, p_phase);
      chk("dur_cycles", dur_cycles, p_cycles);
    end
    chk("cycle_done", cycle_done, due && p_cd);
    chk("cycle_count", cycle_count, m_ccount);
    chk("illegal_err", illegal_err, m_ill);
    chk("seq_err", seq_err, m_seq);
    chk("time_err", time_err, m_time);
  endtask

  task automatic step(input logic [2:0] l, input bit a, input bit p, input bit f, input bit clr);
    bit chg;
    int ended;
    bit due;
    @(negedge clk);
    rst = 1'b1; leds = l; attention = a; preferential = p; force_red = f; err_clr = clr;
    @(posedge clk); #1;
    chg = (l != m_prev);
    ended = m_cnt;
    m_cnt = chg ? 1 : ((m_cnt == SAT) ? SAT : m_cnt + 1);
    m_prev = l;
    if (clr) begin m_ill = 0; m_seq = 0; m_time = 0; end
    due = p_due;
    if (due) begin
      m_state = p_state;
      m_ill = m_ill | p_ill;
      m_seq = m_seq | p_seq;
      m_time = m_time | p_time;
      if (p_cd && m_ccount < 65535) m_ccount++;
    end
    compare(due);
    p_due = 1'b0;
    if (chg) model_event(l, a, p, f, ended);
  endtask

  task automatic seg(input logic [2:0] l, input int n, input bit a, input bit p, input bit f,
                     input int clr_at);
    for (int i = 0; i < n; i++) step(l, a, p, f, i == clr_at);
  endtask

  task automatic reset_cycle(input logic [2:0] l);
    @(negedge clk);
    rst = 1'b0; leds = l; err_clr = 1'b1; attention = 1'b0; preferential = 1'b0; force_red = 1'b0;
    @(posedge clk); #1;
    m_prev = 3'b000; m_cnt = 0; m_state = PH_IDLE; m_ccount = 0;
    m_ill = 0; m_seq = 0; m_time = 0; p_due = 0;
    hist.delete();
    hist.push_back(PH_IDLE);
    compare(1'b0);
    chk("rst_dur_phase", dur_phase, 0);
    chk("rst_dur_cycles", dur_cycles, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] ill_codes[4];
    logic [2:0] code;
    bit mode_blink = 1'b0;
    ill_codes = '{3'b110, 3'b101, 3'b011, 3'b111};

    reset_cycle(3'b000);
    reset_cycle(3'b000);

    // Normal loop
    seg(3'b100, 61, 0, 0, 0, -1);
    seg(3'b010, 7, 0, 0, 0, -1);
    seg(3'b001, 5, 0, 0, 0, -1);
    seg(3'b100, 61, 0, 0, 0, -1);
    chk("t1_cycle_count", cycle_count, 1);
    chk("t1_errors", {illegal_err, seq_err, time_err}, 0);
    seg(3'b010, 7, 0, 0, 0, -1);

    // Preferential green
    seg(3'b001, 5, 0, 1, 0, -1);
    seg(3'b100, 81, 0, 1, 0, -1);
    seg(3'b010, 7, 0, 1, 0, -1);
    chk("t2_pref_ok", time_err, 0);
    seg(3'b001, 5, 0, 1, 0, -1);
    seg(3'b100, 61, 0, 1, 0, -1);
    seg(3'b010, 7, 0, 1, 0, -1);
    chk("t2_pref_short", time_err, 1);
    seg(3'b001, 5, 0, 0, 0, 4);
    chk("t2_cleared", time_err, 0);

    // Force red
    seg(3'b000, 3, 0, 0, 0, -1);
    seg(3'b100, 1, 0, 0, 0, -1);
    seg(3'b001, 5, 0, 0, 1, -1);
    chk("t3_forced_seq", seq_err, 0);
    chk("t3_forced_state", state, 3);
    chk("t3_forced_time", time_err, 0);
    seg(3'b000, 2, 0, 0, 0, -1);
    seg(3'b100, 1, 0, 0, 0, -1);
    seg(3'b001, 5, 0, 0, 0, -1);
    chk("t3_unforced_seq", seq_err, 1);

    // Attention blinking
    seg(3'b000, 3, 1, 0, 0, 0);
    chk("t4_cleared", seq_err, 0);
    seg(3'b010, 3, 1, 0, 0, -1);
    seg(3'b000, 3, 1, 0, 0, -1);
    seg(3'b010, 3, 1, 0, 0, -1);
    seg(3'b000, 3, 1, 0, 0, -1);
    chk("t4_blink_state", state, 5);
    chk("t4_blink_time", time_err, 0);
    seg(3'b010, 5, 1, 0, 0, -1);
    seg(3'b000, 3, 1, 0, 0, -1);
    chk("t4_blink_long", time_err, 1);
    seg(3'b100, 20, 0, 0, 0, -1);

    // Illegal code, err_clr, coincident set/clear
    seg(3'b110, 1, 0, 0, 0, -1);
    seg(3'b100, 10, 0, 0, 0, -1);
    chk("t5_illegal", illegal_err, 1);
    chk("t5_state", state, 1);
    seg(3'b010, 7, 0, 0, 0, 3);
    chk("t5_clear_all", {illegal_err, seq_err, time_err}, 0);
    seg(3'b100, 5, 0, 0, 0, 1);
    chk("t5_set_wins", seq_err, 1);

    // Reset mid-phase, then saturation
    seg(3'b010, 4, 0, 0, 0, -1);
    reset_cycle(3'b010);
    chk("t6_state", state, 0);
    seg(3'b100, 61, 0, 0, 0, -1);
    seg(3'b010, 7, 0, 0, 0, -1);
    chk("t6_exempt", time_err, 0);
    seg(3'b001, 5, 0, 0, 0, -1);
    seg(3'b100, 61, 0, 0, 0, -1);
    seg(3'b010, 7, 0, 0, 0, -1);
    seg(3'b001, 260, 0, 0, 0, -1);
    seg(3'b100, 3, 0, 0, 0, -1);
    chk("t7_sat_time", time_err, 1);
    chk("t7_loops", cycle_count, 2);

    // Randomized segments
    for (int k = 0; k < 80; k++) begin
      int r = $urandom_range(0, 15);
      int len;
      bit a = 1'b0;
      bit p = $urandom_range(0, 1);
      bit f = ($urandom_range(0, 3) == 0);
      int clr_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
      if (r == 0) mode_blink = !mode_blink;
      if (r == 1) begin
        code = ill_codes[$urandom_range(0, 3)];
        len = $urandom_range(1, 3);
      end else if (mode_blink) begin
        code = (leds == 3'b000) ? 3'b010 : 3'b000;
        len = 3;
        a = 1'b1;
      end else begin
        case (leds)
          3'b100:  code = 3'b010;
          3'b010:  code = 3'b001;
          3'b001:  code = 3'b100;
          default: code = 3'b100;
        endcase
        if (r == 2) code = 3'b000;
        if (r == 3) a = 1'b1;
        case (code)
          3'b100:  len = p ? 81 : 61;
          3'b010:  len = 7;
          3'b001:  len = 5;
          default: len = 3;
        endcase
      end
      if ($urandom_range(0, 3) == 0) len = len + $urandom_range(0, 2) - 1;
      if (len < 1) len = 1;
      seg(code, len, a, p, f, clr_at);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive observer on the output side of the traffic light controller.
- Samples `leds` together with the same control inputs the controller receives: attention, preferential, force_red.
- Tracks the phase sequence and measures each phase length in clock cycles (1 cycle = 0.5 s). Reports every measurement and flags illegal codes, illegal transitions and out-of-window durations.
- Used in-system as a safety watchdog and in benches as a self-checking scoreboard.

Parameters:
- CW, 8, width of the duration counter; saturates at 2^CW-1.
- GREEN_CYC, 61, expected normal green length in cycles.
- PREF_GREEN_CYC, 81, expected green length when preferential=1.
- YELLOW_CYC, 7, expected yellow length.
- RED_CYC, 5, expected red length.
- BLINK_CYC, 3, expected length of each attention half-period (lit or dark).
- TOL, 0, allowed +/- deviation in cycles for every duration check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- leds  in  3  observed lamps {green, yellow, red}.
- attention  in  1  observed attention (blink) request.
- preferential  in  1  observed preferential-green request.
- force_red  in  1  observed force-red request.
- err_clr  in  1  clears all sticky error flags.
- state  out  3  monitor state: 0 IDLE, 1 GREEN, 2 YELLOW, 3 RED, 4 BLINK_ON, 5 BLINK_OFF.
- dur_valid  out  1  one-cycle pulse: a phase segment has ended.
- dur_phase  out  3  state code of the segment that ended.
- dur_cycles  out  CW  length of the segment that ended.
- cycle_done  out  1  one-cycle pulse on each completed GREEN->YELLOW->RED->GREEN loop.
- cycle_count  out  16  number of completed loops, saturating.
- illegal_err  out  1  sticky: leds held a code outside {000, 100, 010, 001}.
- seq_err  out  1  sticky: illegal transition.
- time_err  out  1  sticky: duration outside its window.

Behaviour:
- Reset (rst=0 at a rising edge):
  - All outputs go to 0 and state goes to IDLE.
  - The internal previous-leds register goes to 000 and the counter goes to 0.
  - Reset overrides err_clr and any phase in progress; no dur_valid is emitted for an aborted segment.
- Duration counting:
  - A new segment starts on the first cycle in which leds differs from the previous sample. The counter loads 1 on that cycle.
  - The counter increments on each following cycle with unchanged leds and saturates at all ones.
  - The IDLE/000 segment is not measured.
- Reporting latency: leds changes at edge N. At edge N+1, dur_valid=1, dur_phase = old state, dur_cycles = final count. The state update and all error flags land on the same edge.
- State transitions, chosen on leds change:
  - 100 -> GREEN.
  - 010 -> YELLOW if the previous state was GREEN; otherwise BLINK_ON.
  - 001 -> RED.
  - 000 -> BLINK_OFF if attention=1; otherwise IDLE.
- Legal transitions (no seq_err):
  - IDLE->GREEN, IDLE->RED, IDLE->BLINK_ON.
  - GREEN->YELLOW.
  - GREEN->RED only when force_red=1 in the change cycle.
  - YELLOW->RED, RED->GREEN.
  - BLINK_ON<->BLINK_OFF.
  - Any state -> IDLE.
  - Any state -> BLINK_OFF when attention=1.
  - BLINK_* -> GREEN when attention=0.
  - Every other transition sets seq_err.
- Duration checks (set time_err if |dur - exp| > TOL):
  - GREEN->YELLOW: exp = preferential ? PREF_GREEN_CYC : GREEN_CYC, with preferential sampled in the change cycle.
  - YELLOW->RED: exp = YELLOW_CYC.
  - RED->GREEN: exp = RED_CYC.
  - BLINK_ON->BLINK_OFF and BLINK_OFF->BLINK_ON: exp = BLINK_CYC.
- Exemptions from duration checks:
  - The first GREEN after IDLE, because preset may extend it.
  - The first BLINK_OFF after entry.
  - Forced red.
  - Any segment ending into IDLE.
  - Any segment whose counter saturated. A saturated segment sets time_err only if its state was YELLOW or RED.
- Illegal leds codes (110, 101, 011, 111):
  - Set illegal_err and force state to IDLE.
  - No dur_valid for the illegal segment.
  - The segment preceding it still reports.
- cycle_done:
  - Asserts with the dur_valid of RED->GREEN when the RED was entered from YELLOW and that YELLOW from GREEN.
  - cycle_count increments on the same edge and saturates at 0xFFFF.
- Error flags and err_clr:
  - err_clr=1 clears all three flags at the next edge.
  - If a new error is detected on the same edge, set wins.

Test Plan:
1. Normal loop. Release rst; drive 100x61, 010x7, 001x5, 100x61, 010.
   - dur_valid/(phase, cycles): (1,61), (2,7), (3,5), (1,61).
   - cycle_done pulses once; cycle_count=1; all errors 0.
2. Preferential. preferential=1; drive 100 following RED, then 100x81, 010, 001x5.
   - (1,81) reported with time_err=0.
   - Repeat with 100x61: time_err=1 one cycle after the 010 change.
3. Force red. From IDLE drive 100x1 then 001 with force_red=1.
   - seq_err=0; state=3 one cycle later; no time_err.
   - Repeat with force_red=0: seq_err=1.
4. Attention. attention=1; drive 000x3, 010x3, 000x3, 010x3.
   - States alternate 5/4; dur_cycles=3 each; time_err=0.
   - A 010x5 half-period sets time_err.
5. Illegal code. Drive 110 for 1 cycle mid-GREEN.
   - illegal_err=1, state=0 next cycle.
   - err_clr pulse -> all flags 0 next edge.
   - err_clr coincident with a new seq_err -> seq_err stays 1.
6. Reset mid-phase. rst=0 during YELLOW count 4.
   - All outputs 0 next edge; no dur_valid.
   - After release, 100x61 reports (1,61) exempt from checking.
